// File: rtl/wb_cmd_pkg.sv
// ============================================================================
// Module      : wb_cmd_pkg
// Description : Shared types and constants for the Wishbone command initiator:
//               FSM state encoding, response status codes, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_cmd_pkg;

  // Default bus geometry and abort limit
  localparam int unsigned WB_CMD_AW_DEFAULT      = 32;
  localparam int unsigned WB_CMD_DW_DEFAULT      = 32;
  localparam int unsigned WB_CMD_TIMEOUT_DEFAULT = 256;

  // Width of the abort counter; bounds the legal TIMEOUT_CYCLES range
  localparam int unsigned WB_CMD_TO_CNT_W = 16;

  // Initiator FSM state, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_cmd_state_e;

  // Response status codes (2'b11 is reserved and never produced)
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage : wb_cmd_pkg

`default_nettype wire

// File: rtl/wb_cmd_timeout.sv
// ============================================================================
// Module      : wb_cmd_timeout
// Description : Bus-cycle abort counter. Cleared when a cycle starts, counts
//               each unterminated bus cycle, flags expiry once TIMEOUT_CYCLES
//               bus cycles have elapsed without a termination.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_timeout
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_CMD_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Counter value seen on the edge where the cycle must be abandoned
  localparam logic [WB_CMD_TO_CNT_W-1:0] LIMIT = WB_CMD_TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WB_CMD_TO_CNT_W-1:0] cnt_q;
  logic [WB_CMD_TO_CNT_W-1:0] cnt_d;

  // Clear has priority so every new bus cycle starts counting from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule : wb_cmd_timeout

`default_nettype wire

// File: rtl/wb_cmd_initiator.sv
// ============================================================================
// Module      : wb_cmd_initiator
// Description : Wishbone classic-cycle initiator. Converts a valid/ready
//               command stream into single read/write bus cycles and returns
//               each result on a valid/ready response stream. All outputs
//               are registered.
// Options     : WB_CMD_TIMEOUT_EN - when defined, an unterminated bus cycle
//               is aborted after TIMEOUT_CYCLES cycles with status 2'b10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int unsigned AW             = WB_CMD_AW_DEFAULT,
  parameter int unsigned DW             = WB_CMD_DW_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = WB_CMD_TIMEOUT_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  // Command stream
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  input  logic [DW-1:0]     cmd_dat_i,
  // Response stream
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic [1:0]        rsp_status_o,
  // Wishbone initiator port
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  // Status
  output logic              busy_o
);

  localparam int unsigned SW = DW / 8;

  // Elaboration-time sanity checks on the configuration
  if ((DW % 8) != 0 || DW == 0) begin : g_bad_dw
    $error("wb_cmd_initiator: DW must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_initiator: TIMEOUT_CYCLES must be in 2..65535");
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  wb_cmd_state_e   state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            busy_q, busy_d;

  // Combinational decode of handshakes and bus termination
  logic            w_accept;
  logic            w_rsp_done;
  logic            w_term;
  logic [1:0]      w_term_status;
  logic [DW-1:0]   w_term_dat;
  logic            w_expired;

  assign w_accept   = (state_q == IDLE) && cmd_valid_i && cmd_ready_q;
  assign w_rsp_done = (state_q == RESP) && rsp_valid_q && rsp_ready_i;

`ifdef WB_CMD_TIMEOUT_EN
  logic w_to_en;

  // Count only bus cycles in which the slave gave no termination
  assign w_to_en = (state_q == BUS) && !wbm_ack_i && !wbm_err_i;

  wb_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .clr_i     (w_accept),
    .en_i      (w_to_en),
    .expired_o (w_expired)
  );
`else
  // Without the abort counter the bus cycle waits for the slave forever
  assign w_expired = 1'b0;
`endif

  // Resolve the termination cause: err beats ack, both beat the timeout
  always_comb begin
    w_term        = 1'b0;
    w_term_status = ST_OK;
    w_term_dat    = '0;
    if (state_q == BUS) begin
      if (wbm_err_i) begin
        w_term        = 1'b1;
        w_term_status = ST_ERR;
      end else if (wbm_ack_i) begin
        w_term        = 1'b1;
        w_term_status = ST_OK;
        w_term_dat    = we_q ? '0 : wbm_dat_i;
      end else if (w_expired) begin
        w_term        = 1'b1;
        w_term_status = ST_TIMEOUT;
      end
    end
  end

  // State register plus all registered outputs; reset drops the bus at once
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      wdat_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state decode: IDLE -> BUS on accept, BUS -> RESP on termination,
  // RESP -> IDLE on response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept)   state_d = BUS;
      BUS:     if (w_term)     state_d = RESP;
      RESP:    if (w_rsp_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output decode: compute next values of the registered outputs
  always_comb begin
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = cmd_we_i;
          sel_d       = cmd_sel_i;
          adr_d       = cmd_adr_i;
          wdat_d      = cmd_dat_i;
        end
      end
      BUS: begin
        // Address/data stay as last driven after the cycle ends
        if (w_term) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = w_term_status;
          rsp_dat_d    = w_term_dat;
        end
      end
      RESP: begin
        if (w_rsp_done) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        cyc_d       = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output wiring: strobe always mirrors cycle (no bursts, no pipelining)
  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = wdat_q;
  assign busy_o       = busy_q;

endmodule : wb_cmd_initiator

`default_nettype wire

// File: tb/tb_wb_cmd_initiator.sv
// ============================================================================
// Module      : tb_wb_cmd_initiator
// Description : Self-checking bench for wb_cmd_initiator. A small slave model
//               terminates cycles after a chosen wait; responses are checked
//               against expectations computed from the protocol rules.
//               Honours WB_CMD_TIMEOUT_EN (abort limit set to 8 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_initiator;

  localparam int TO = 8;
`ifdef WB_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_initiator #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Drive one command through the DUT. The slave terminates in the bus cycle
  // numbered wait_cyc (0 = first cycle with cyc high; negative = never).
  // Records what was observed; callers do the comparisons.
  task automatic run_txn(
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [3:0]  sel,
    input  logic [31:0] wdat,
    input  int          wait_cyc,
    input  logic        t_ack,
    input  logic        t_err,
    input  logic [31:0] rdata,
    input  int          hold,
    output logic [1:0]  st,
    output logic [31:0] rd,
    output int          lat,
    output int          cyc_n,
    output int          bus_bad,
    output int          stall_bad,
    output logic        post_ok
  );
    int g;
    int bc;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = wdat;
    g = 0;
    while (cmd_ready_o !== 1'b1 && g < 50) begin tick(); g++; end
    tick();  // accept edge; now in the first cycle after acceptance
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'($urandom); cmd_adr_i = $urandom; cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
    lat = 1; cyc_n = 0; bus_bad = 0; bc = 0; stall_bad = 0;
    while (rsp_valid_o !== 1'b1 && lat < 400) begin
      if (wbm_cyc_o === 1'b1) begin
        cyc_n++;
        if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr || wbm_sel_o !== sel ||
            (we && wbm_dat_o !== wdat) || cmd_ready_o !== 1'b0 || busy_o !== 1'b1)
          bus_bad++;
        if (bc == wait_cyc) begin
          wbm_ack_i = t_ack; wbm_err_i = t_err; wbm_dat_i = rdata;
        end else begin
          wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
        end
        bc++;
      end else begin
        bus_bad++;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      end
      tick();
      lat++;
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) bus_bad++;
    st = rsp_status_o; rd = rsp_dat_o;
    // Offer another command while the response is back-pressured
    cmd_valid_i = 1'b1; cmd_we_i = 1'($urandom); cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid_o !== 1'b1 || rsp_status_o !== st || rsp_dat_o !== rd ||
          cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0 || busy_o !== 1'b1)
        stall_bad++;
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    post_ok = (rsp_valid_o === 1'b0) && (cmd_ready_o === 1'b1) && (busy_o === 1'b0) && (wbm_cyc_o === 1'b0);
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_sel_i = 0; cmd_dat_i = 0;
    rsp_ready_i = 0; wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    repeat (3) tick();
    n_cmp++;
    if ({cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 100000", {cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o});
    end
    n_cmp++;
    if ({rsp_dat_o, rsp_status_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
      n_bad++; $display("FAIL reset_data: got rsp_dat %h st %b adr %h dat %h sel %h expected all 0", rsp_dat_o, rsp_status_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    wb_rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got ready %b busy %b expected 1 0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_write();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    run_txn(1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, st, rd, lat, cn, bb, sb, pk);
    n_cmp++; if (bb !== 0)   begin n_bad++; $display("FAIL write_bus: got %0d bad bus cycles expected 0", bb); end
    n_cmp++; if (cn !== 3)   begin n_bad++; $display("FAIL write_cyc_len: got %0d expected 3", cn); end
    n_cmp++; if (lat !== 4)  begin n_bad++; $display("FAIL write_latency: got %0d expected 4", lat); end
    n_cmp++; if (st !== 2'b00) begin n_bad++; $display("FAIL write_status: got %b expected 00", st); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL write_rdat: got %h expected 0", rd); end
    n_cmp++; if (pk !== 1'b1) begin n_bad++; $display("FAIL write_handshake: got %b expected 1", pk); end
  endtask

  task automatic test_read();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    run_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h1234_5678, 0, st, rd, lat, cn, bb, sb, pk);
    n_cmp++; if (lat !== 2)  begin n_bad++; $display("FAIL read_latency: got %0d expected 2", lat); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL read_rdat: got %h expected 12345678", rd); end
    n_cmp++; if (st !== 2'b00) begin n_bad++; $display("FAIL read_status: got %b expected 00", st); end
    n_cmp++; if (cn !== 1 || bb !== 0) begin n_bad++; $display("FAIL read_bus: got cyc %0d bad %0d expected 1 0", cn, bb); end
  endtask

  task automatic test_backpressure();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    run_txn(1'b0, 32'h3000_0020, 4'h3, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0001, 5, st, rd, lat, cn, bb, sb, pk);
    n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL bp_stall: got %0d unstable cycles expected 0", sb); end
    n_cmp++; if (rd !== 32'hCAFE_0001 || pk !== 1'b1) begin n_bad++; $display("FAIL bp_rsp: got %h/%b expected cafe0001/1", rd, pk); end
    // next command goes through only now, with normal latency
    run_txn(1'b1, 32'h3000_0024, 4'h1, 32'h0000_00A5, 0, 1'b1, 1'b0, 32'h0, 0, st, rd, lat, cn, bb, sb, pk);
    n_cmp++; if (lat !== 2 || bb !== 0) begin n_bad++; $display("FAIL bp_next: got lat %0d bad %0d expected 2 0", lat, bb); end
  endtask

  task automatic test_error();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    run_txn(1'b0, 32'h3000_0030, 4'hF, 32'h0, 1, 1'b1, 1'b1, 32'h5555_AAAA, 0, st, rd, lat, cn, bb, sb, pk);
    n_cmp++; if (st !== 2'b01) begin n_bad++; $display("FAIL err_status: got %b expected 01", st); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_rdat: got %h expected 0", rd); end
    n_cmp++; if (cn !== 2 || bb !== 0) begin n_bad++; $display("FAIL err_bus: got cyc %0d bad %0d expected 2 0", cn, bb); end
  endtask

  task automatic test_timeout();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    if (TO_EN) begin
      run_txn(1'b0, 32'h3000_0040, 4'hF, 32'h0, -1, 1'b0, 1'b0, 32'h0, 0, st, rd, lat, cn, bb, sb, pk);
      n_cmp++; if (cn !== TO) begin n_bad++; $display("FAIL to_cyc_len: got %0d expected %0d", cn, TO); end
      n_cmp++; if (st !== 2'b10 || rd !== 32'h0) begin n_bad++; $display("FAIL to_status: got %b/%h expected 10/0", st, rd); end
      // ack on the final permitted cycle beats the abort
      run_txn(1'b0, 32'h3000_0044, 4'hF, 32'h0, TO - 1, 1'b1, 1'b0, 32'h0BAD_F00D, 0, st, rd, lat, cn, bb, sb, pk);
      n_cmp++; if (st !== 2'b00 || rd !== 32'h0BAD_F00D || cn !== TO) begin n_bad++; $display("FAIL to_edge_ack: got %b/%h/%0d expected 00/0badf00d/%0d", st, rd, cn, TO); end
    end else begin
      run_txn(1'b0, 32'h3000_0040, 4'hF, 32'h0, 99, 1'b1, 1'b0, 32'h7777_1111, 0, st, rd, lat, cn, bb, sb, pk);
      n_cmp++; if (cn !== 100 || bb !== 0) begin n_bad++; $display("FAIL noto_cyc_len: got %0d bad %0d expected 100 0", cn, bb); end
      n_cmp++; if (st !== 2'b00 || rd !== 32'h7777_1111) begin n_bad++; $display("FAIL noto_status: got %b/%h expected 00/77771111", st, rd); end
    end
  endtask

  task automatic test_late_ack();
    int bad = 0;
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL late_ack: got %0d disturbed cycles expected 0", bad); end
  endtask

  task automatic test_reset_midbus();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0050; cmd_sel_i = 4'hF; cmd_dat_i = 32'h1;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    n_cmp++; if (wbm_cyc_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got cyc %b expected 1", wbm_cyc_o); end
    #2 wb_rst_ni = 1'b0;
    #1;
    n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_drop: got cyc %b stb %b expected 0 0", wbm_cyc_o, wbm_stb_o); end
    tick();
    wb_rst_ni = 1'b1;
    tick();
    n_cmp++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_after: got ready %b busy %b rv %b expected 1 0 0", cmd_ready_o, busy_o, rsp_valid_o); end
    run_txn(1'b0, 32'h3000_0054, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h2468_ACE0, 0, st, rd, lat, cn, bb, sb, pk);
    n_cmp++; if (rd !== 32'h2468_ACE0 || lat !== 2) begin n_bad++; $display("FAIL rst_recover: got %h lat %0d expected 2468ace0 2", rd, lat); end
  endtask

  task automatic test_random();
    logic [1:0] st; logic [31:0] rd; int lat, cn, bb, sb; logic pk;
    logic we, err, ack; logic [31:0] adr, wdat, rdat; logic [3:0] sel; int wt, hold;
    logic [1:0] e_st; logic [31:0] e_rd; int e_cyc;
    for (int k = 0; k < 24; k++) begin
      we = 1'($urandom); adr = $urandom; sel = 4'($urandom); wdat = $urandom; rdat = $urandom;
      wt = int'($urandom_range(0, TO_EN ? 10 : 5)); hold = int'($urandom_range(0, 3));
      err = ($urandom_range(0, 3) == 0); ack = err ? 1'($urandom) : 1'b1;
      // Reference: abort if the slave would answer after the limit
      if (TO_EN && wt >= TO) begin
        e_st = 2'b10; e_rd = 32'h0; e_cyc = TO;
      end else begin
        e_cyc = wt + 1;
        if (err) begin e_st = 2'b01; e_rd = 32'h0; end
        else begin e_st = 2'b00; e_rd = we ? 32'h0 : rdat; end
      end
      run_txn(we, adr, sel, wdat, wt, ack, err, rdat, hold, st, rd, lat, cn, bb, sb, pk);
      n_cmp++;
      if (st !== e_st || rd !== e_rd || cn !== e_cyc || lat !== e_cyc + 1 || bb !== 0 || sb !== 0 || pk !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_%0d: got st %b rd %h cyc %0d lat %0d bad %0d/%0d hs %b expected st %b rd %h cyc %0d lat %0d bad 0/0 hs 1",
                 k, st, rd, cn, lat, bb, sb, pk, e_st, e_rd, e_cyc, e_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_error();
    test_timeout();
    test_late_ack();
    test_reset_midbus();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_wb_cmd_initiator

`default_nettype wire
